edge_event_arbiter: RTL and testbench

Collects one-cycle rising/falling edge pulses from N input conditioners, one per button or pin channel. Holds at most one pending edge per channel. Round-robin arbitrates among channels with pending edges. Presents one event at a time to a downstream consumer (CPU/FSM) over a registered valid/ready interface.

---
 rtl/edge_event_arbiter_pkg.sv | 18 +
 rtl/edge_event_arbiter_rr_picker.sv | 33 +++
 rtl/edge_event_arbiter.sv | 119 +++++++++++
 tb/tb_edge_event_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter: edge-type encodings, output FSM states
// and the width of an event record {chan, fall}.
package edge_event_arbiter_pkg;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // An event record is the channel index plus one edge-type bit.
  function automatic int ev_rec_w(input int idxw);
    return idxw + 1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first requester after ptr, wrapping mod N.
// Handles non-power-of-two N, so it can be reused by other arbiters.
module rr_picker #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any_req
);

  logic [IDXW:0]   sum;
  logic [IDXW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      // Wrap explicitly so the search order stays ptr+1 .. ptr+N for any N.
      sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(N)) sum = sum - (IDXW+1)'(N);
      cand = sum[IDXW-1:0];
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: one pending edge slot per channel, round-robin grant, registered
// valid/ready event output. Define EDGE_EVENT_OVERRUN_EN to enable the sticky overrun flag.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    rising,
  input  logic [N-1:0]    falling,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [IDXW-1:0] ev_chan,
  output logic            ev_fall,
  output logic            overrun
);

  localparam int EVW = ev_rec_w(IDXW);

  logic [N-1:0]    pv;
  logic [N-1:0]    pf;
  logic [N-1:0]    edge_in;
  logic [N-1:0]    gnt_vec;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gnt_idx;
  logic            any_req;
  logic            grant_en;
  state_e          state_q;
  state_e          state_d;
  logic [EVW-1:0]  ev_q;

  assign edge_in = rising | falling;

  rr_picker #(.N(N), .IDXW(IDXW)) u_pick (
    .req     (pv),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_comb begin
    gnt_vec = '0;
    if (grant_en) gnt_vec[gnt_idx] = 1'b1;
  end

  // A slot being granted this cycle can refill from a same-cycle edge; falling wins ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      pf <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((!pv[i] || gnt_vec[i]) && edge_in[i]) begin
          pv[i] <= 1'b1;
          pf[i] <= falling[i] ? EDGE_FALL : EDGE_RISE;
        end else if (gnt_vec[i]) begin
          pv[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_en = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ev_ready) begin
          if (any_req) grant_en = 1'b1;
          else         state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ev_q    <= {{IDXW{1'b0}}, EDGE_RISE};
      ptr     <= IDXW'(N-1);
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        ev_q <= {gnt_idx, pf[gnt_idx]};
        ptr  <= gnt_idx;
      end
    end
  end

  assign ev_valid = (state_q == ST_HOLD);
  assign ev_chan  = ev_q[EVW-1:1];
  assign ev_fall  = ev_q[0];

`ifdef EDGE_EVENT_OVERRUN_EN
  logic [N-1:0] drop;
  logic         overrun_q;

  assign drop = pv & ~gnt_vec & edge_in;

  always_ff @(posedge clk) begin
    if (reset)      overrun_q <= 1'b0;
    else if (|drop) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N=4); expectations are hand-derived.
module tb_edge_event_arbiter;

  localparam int N    = 4;
  localparam int IDXW = 2;
`ifdef EDGE_EVENT_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rising;
  logic [N-1:0]    falling;
  logic            ev_valid;
  logic            ev_ready;
  logic [IDXW-1:0] ev_chan;
  logic            ev_fall;
  logic            overrun;

  int n_cmp  = 0;
  int n_miss = 0;

  edge_event_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rising   (rising),
    .falling  (falling),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_chan  (ev_chan),
    .ev_fall  (ev_fall),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    rising  = '0;
    falling = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_ev(input string tag, input logic v, input logic [IDXW-1:0] c, input logic f);
    chk({tag, ".valid"}, 32'(ev_valid), 32'(v));
    if (v) begin
      chk({tag, ".chan"}, 32'(ev_chan), 32'(c));
      chk({tag, ".fall"}, 32'(ev_fall), 32'(f));
    end
  endtask

  initial begin
    reset    = 1'b1;
    rising   = '0;
    falling  = '0;
    ev_ready = 1'b1;
    tick();
    do_reset();

    // reset state
    chk("rst.valid",   32'(ev_valid), 0);
    chk("rst.chan",    32'(ev_chan),  0);
    chk("rst.fall",    32'(ev_fall),  0);
    chk("rst.overrun", 32'(overrun),  0);

    // 1: single rising edge on ch2
    rising = 4'b0100;
    tick();
    rising = '0;
    chk("t1.early", 32'(ev_valid), 0);
    tick();
    chk_ev("t1.ev", 1'b1, 2'd2, 1'b0);
    tick();
    chk("t1.idle", 32'(ev_valid), 0);

    // 2: simultaneous rising on ch0, ch1, ch3
    do_reset();
    rising = 4'b1011;
    tick();
    rising = '0;
    tick(); chk_ev("t2.e0", 1'b1, 2'd0, 1'b0);
    tick(); chk_ev("t2.e1", 1'b1, 2'd1, 1'b0);
    tick(); chk_ev("t2.e2", 1'b1, 2'd3, 1'b0);
    tick(); chk("t2.idle", 32'(ev_valid), 0);

    // 3: fairness with ch0/ch1 pulsed every cycle
    do_reset();
    rising = 4'b0011;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_ev($sformatf("t3.e%0d", i), 1'b1, (i % 2 == 0) ? 2'd0 : 2'd1, 1'b0);
    end
    rising = '0;
    chk("t3.overrun", 32'(overrun), 32'(OVR_EN));

    // 4: backpressure, extra ch3 edge dropped
    do_reset();
    ev_ready = 1'b0;
    falling  = 4'b1000;
    tick();
    falling = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk_ev($sformatf("t4.hold%0d", i), 1'b1, 2'd3, 1'b1);
      rising = (i < 2) ? 4'b1000 : 4'b0000;
      tick();
    end
    chk("t4.overrun", 32'(overrun), 32'(OVR_EN));
    ev_ready = 1'b1;
    tick();
    chk_ev("t4.next", 1'b1, 2'd3, 1'b0);
    tick();
    chk("t4.idle", 32'(ev_valid), 0);
    chk("t4.overrun_sticky", 32'(overrun), 32'(OVR_EN));

    // 5: reset mid-operation
    do_reset();
    ev_ready = 1'b0;
    rising   = 4'b0001;
    tick();
    rising = 4'b0110;
    tick();
    rising = '0;
    chk_ev("t5.pre", 1'b1, 2'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5.valid",   32'(ev_valid), 0);
    chk("t5.chan",    32'(ev_chan),  0);
    chk("t5.overrun", 32'(overrun),  0);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5.quiet%0d", i), 32'(ev_valid), 0);
    end

    // 6: grant-and-refill on ch1
    do_reset();
    falling = 4'b0010;
    tick();
    falling = '0;
    rising  = 4'b0010;
    tick();
    rising = '0;
    chk_ev("t6.fall", 1'b1, 2'd1, 1'b1);
    tick();
    chk_ev("t6.rise", 1'b1, 2'd1, 1'b0);
    tick();
    chk("t6.idle",    32'(ev_valid), 0);
    chk("t6.overrun", 32'(overrun),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule
